// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg
//   Shared definitions for the 8-way round-robin arbiter:
//   requester count, grant index width and the arbiter state encoding.
//   No ports; imported by the interface, the decoder and the arbiter top.

package rr_arbiter8_pkg;

    // Number of requesters and the width of a binary requester index
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    // Arbiter states: IDLE owns nothing, GRANT has exactly one owner
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if
//   Request/grant bundle between requesters and the round-robin arbiter.
//   Signals:
//     en        - arbiter enable, low forces no grant
//     req       - level-sensitive request vector, bit i = requester i
//     gnt       - one-hot grant, all-zero when nothing is granted
//     gnt_idx   - binary index of the current grantee, 0 when idle
//     gnt_valid - high while a grant is active
//   Modports:
//     master - requester side (drives en/req, observes grant)
//     slave  - arbiter side (observes en/req, drives grant)

interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

// File: rtl/rr_arbiter8_grant_decoder.sv
// grant_decoder
//   3-to-8 one-hot decoder with enable, used to build the grant vector
//   from the registered grant index.
//   Ports:
//     idx_i    - binary index to decode
//     en_i     - when low the output is all-zero
//     onehot_o - one-hot decode of idx_i, or 0 when disabled

module grant_decoder
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8
//   8-requester round-robin arbiter with a hold limit. A rotating pointer
//   sets the search priority (ptr, ptr+1, ... ptr+7 mod 8). The owner keeps
//   the grant until it drops its request or until it has held it MAX_HOLD
//   cycles while someone else waits. Hand-over happens with no idle cycle.
//   Parameters:
//     MAX_HOLD - longest run of grant cycles while others wait (2..15)
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - rr_arbiter8_if slave modport (en, req in; gnt, gnt_idx,
//             gnt_valid out, all registered)

module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 15
)
(
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    localparam logic [0:0]       S_IDLE    = IDLE;
    localparam logic [0:0]       S_GRANT   = GRANT;
    localparam logic [3:0]       HOLD_LAST = 4'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [0:0]         state_q,    state_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0] held_mask;
    logic [NUM_REQ-1:0] search_vec;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   cand;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               holder_req;

    // Round-robin search. While idle the search starts at ptr over all
    // requests. While granting, the only useful answer is the next owner,
    // so the current owner is masked out and the search starts just past
    // it; this is exactly the order a release or timeout would produce
    // after moving ptr to owner+1, so one search serves every case.
    always_comb begin
        held_mask        = '0;
        held_mask[idx_q] = 1'b1;
        if (state_q == S_GRANT) begin
            search_vec   = bus.req & ~held_mask;
            search_start = idx_q + IDX_ONE;
        end else begin
            search_vec   = bus.req;
            search_start = ptr_q;
        end

        // Walk the order backwards so the earliest hit is the last written
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = search_start + IDX_W'(k);
            if (search_vec[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign holder_req = bus.req[idx_q];

    // Next-state logic. Disable wins over everything except reset; ptr
    // only moves when an owner gives up the grant (release or timeout).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;

        if (!bus.en) begin
            state_d    = S_IDLE;
            idx_d      = '0;
            hold_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            if (pick_valid) begin
                state_d    = S_GRANT;
                idx_d      = pick_idx;
                hold_cnt_d = '0;
            end
        end else if (!holder_req) begin
            // Owner released: advance ptr and hand over or go idle
            ptr_d = idx_q + IDX_ONE;
            if (pick_valid) begin
                idx_d      = pick_idx;
                hold_cnt_d = '0;
            end else begin
                state_d    = S_IDLE;
                idx_d      = '0;
                hold_cnt_d = '0;
            end
        end else if (hold_cnt_q >= HOLD_LAST) begin
            // Hold limit reached: rotate if someone waits, else keep the
            // grant and start a fresh hold window
            hold_cnt_d = '0;
            if (pick_valid) begin
                ptr_d = idx_q + IDX_ONE;
                idx_d = pick_idx;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Outputs come straight from registers; gnt is a pure decode of them
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == S_GRANT);

    grant_decoder u_grant_decoder (
        .idx_i    (idx_q),
        .en_i     (state_q == S_GRANT),
        .onehot_o (bus.gnt)
    );

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, default 15; maximum consecutive cycles one requester holds the grant while others wait (legal range 2..15).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: en  input  1  arbiter enable; low forces no grant.
REQ-005 Port: req  input  8  request vector, bit i = requester i, level-sensitive.
REQ-006 Port: gnt  output  8  one-hot grant; all-zero when no grant.
REQ-007 Port: gnt_idx  output  3  binary index of current grantee; 0 when gnt_valid low.
REQ-008 Port: gnt_valid  output  1  high while a grant is active.

Function
REQ-009 FSM states: IDLE (no grant), GRANT (one requester owns the resource).
REQ-010 gnt, gnt_idx and gnt_valid shall be registered; a new grant is visible one cycle after the qualifying req/en edge.
REQ-011 gnt shall equal the 3-to-8 one-hot decode of gnt_idx when gnt_valid=1, else 8'h00.
REQ-012 Rotating pointer ptr[2:0] shall define priority: search order ptr, ptr+1, ... ptr+7, modulo 8.
REQ-013 IDLE: if en=1 and req!=0, select the first set bit in search order, enter GRANT, clear hold_cnt.
REQ-014 GRANT, release: if req[gnt_idx]=0, set ptr=gnt_idx+1 mod 8; if another requester is pending, grant it the next cycle with no bubble cycle, else enter IDLE.
REQ-015 GRANT, timeout: when hold_cnt reaches MAX_HOLD-1 with req[gnt_idx] still 1 and another requester pending, rotate as in REQ-014.
REQ-016 GRANT, timeout with no other requester: retain the grant and clear hold_cnt.
REQ-017 hold_cnt shall increment every GRANT cycle without release or rotation; 4 bits wide; never wraps past MAX_HOLD-1.
REQ-018 en=0 in any state: next cycle gnt_valid=0, gnt=0, state IDLE; ptr unchanged; hold_cnt cleared.
REQ-019 New requests arriving during GRANT shall not preempt before release or timeout, regardless of index.
REQ-020 Wrap-around: a grant to index 7 followed by release shall set ptr=0.
REQ-021 At most one bit of gnt shall be high in any cycle.

Reset
REQ-022 rst_n=0 sampled at clk shall force state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=0, gnt_valid=0.
REQ-023 Reset asserted mid-grant shall drop the grant on the next edge; the first post-reset grant follows priority from index 0.
REQ-024 Reset shall take precedence over en and req.

Structure
REQ-025 A shared package shall hold the state enum (IDLE, GRANT), the requester count constant (8) and the index width constant (3).
REQ-026 The one-hot output decode shall be a sub-module grant_decoder (3-bit index plus enable in, 8-bit one-hot out).
REQ-027 The round-robin search shall be combinational logic inside rr_arbiter8.

Verification
REQ-028 Reset then req=8'h00 -> gnt=8'h00 and gnt_valid=0 indefinitely.
REQ-029 After reset, req=8'h24 -> gnt=8'h04 one cycle later; drop req[2] -> next cycle gnt=8'h20, ptr=3.
REQ-030 With MAX_HOLD=15 and req=8'h81 held continuously: gnt alternates 8'h01/8'h80 every 15 cycles; wrap from 7 returns to 0.
REQ-031 Single requester req=8'h10 held for 40 cycles -> gnt=8'h10 continuously; hold_cnt restarts at timeout; no gap.
REQ-032 en deasserted during grant to index 5 -> gnt=8'h00 next cycle; en reasserted with req=8'h20 -> gnt=8'h20 one cycle later.
REQ-033 rst_n pulsed low mid-grant to index 6 with req=8'hC0 -> gnt=8'h00 next edge; after release, gnt=8'h40 (search restarts from ptr=0).
